// File: rtl/bidir_shift_feeder_if.sv
// Handshake and serial-output bundle between an upstream word source,
// the feeder, and the downstream bidirectional shift register.
interface bidir_shift_feeder_if #(
   parameter int unsigned MSB = 8
);
   logic           in_valid;
   logic           in_ready;
   logic [MSB-1:0] in_data;
   logic           in_dir;
   logic           pause;
   logic           d;
   logic           en;
   logic           dir;
   logic           circular;
   logic           carry_in;
   logic           word_done;
   logic           busy;

   modport master (
      output in_valid, in_data, in_dir, pause,
      input  in_ready, d, en, dir, circular, carry_in, word_done, busy
   );

   modport slave (
      input  in_valid, in_data, in_dir, pause,
      output in_ready, d, en, dir, circular, carry_in, word_done, busy
   );
endinterface

// File: rtl/bidir_shift_feeder.sv
// Serialises queued parallel words, one bit per enabled cycle, into a
// bidirectional shift register; LSB first for right shift, MSB first for left.
module bidir_shift_feeder #(
   parameter int unsigned MSB = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   bidir_shift_feeder_if.slave   bus
);
   localparam int unsigned CW = (MSB > 1) ? $clog2(MSB) : 1;
   localparam int unsigned EW = MSB + 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state, state_nxt;
   logic [EW-1:0]   fifo_mem [2];
   logic [EW-1:0]   head;
   logic            wr_ptr, rd_ptr;
   logic [1:0]      count;
   logic            push, pop;
   logic            fifo_full, fifo_empty;

   logic [MSB-1:0]  cur_word;
   logic            cur_dir;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [CW-1:0]   bit_idx;
   logic            last_bit;

   logic            d_q, en_q, dir_q, done_q, last_q;
   logic            d_nxt, en_nxt, dir_nxt, last_nxt;

   assign fifo_full  = (count == 2'd2);
   assign fifo_empty = (count == 2'd0);
   assign push       = bus.in_valid && !fifo_full;
   assign head       = fifo_mem[rd_ptr];
   assign last_bit   = (cnt == CW'(MSB - 1));
   assign bit_idx    = cur_dir ? (CW'(MSB - 1) - cnt) : cnt;

   // State register and all datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
         cnt      <= '0;
         cur_word <= '0;
         cur_dir  <= 1'b0;
         d_q      <= 1'b0;
         en_q     <= 1'b0;
         dir_q    <= 1'b0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop) begin
            rd_ptr   <= ~rd_ptr;
            cur_dir  <= head[MSB];
            cur_word <= head[MSB-1:0];
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         d_q    <= d_nxt;
         en_q   <= en_nxt;
         dir_q  <= dir_nxt;
         last_q <= last_nxt;
         done_q <= last_q;
      end
   end

   // FIFO storage needs no reset; occupancy is tracked by count
   always_ff @(posedge clk) begin
      if (!rst && push) fifo_mem[wr_ptr] <= {bus.in_dir, bus.in_data};
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!fifo_empty) state_nxt = SHIFT;
         SHIFT:   if (!bus.pause && last_bit && fifo_empty) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs, counter and FIFO pop
   always_comb begin
      pop      = 1'b0;
      cnt_nxt  = cnt;
      d_nxt    = d_q;
      en_nxt   = 1'b0;
      dir_nxt  = dir_q;
      last_nxt = 1'b0;
      case (state)
         IDLE: begin
            d_nxt = 1'b0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               cnt_nxt = '0;
            end
         end
         SHIFT: begin
            // A paused edge freezes d and the counter and drops en
            if (!bus.pause) begin
               en_nxt   = 1'b1;
               d_nxt    = cur_word[bit_idx];
               dir_nxt  = cur_dir;
               last_nxt = last_bit;
               if (last_bit) begin
                  cnt_nxt = '0;
                  pop     = !fifo_empty;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   assign bus.in_ready  = !fifo_full;
   assign bus.d         = d_q;
   assign bus.en        = en_q;
   assign bus.dir       = dir_q;
   assign bus.word_done = done_q;
   assign bus.circular  = 1'b0;
   assign bus.carry_in  = 1'b0;
   assign bus.busy      = (state == SHIFT) || !fifo_empty;
endmodule

// File: tb/tb_bidir_shift_feeder.sv
// Scoreboard bench for bidir_shift_feeder: stimulus queues expected bits and
// words; a negedge monitor checks them against the serial stream.
module tb_bidir_shift_feeder;
   localparam int unsigned MSB = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   bidir_shift_feeder_if #(.MSB(MSB)) bus ();

   bidir_shift_feeder #(.MSB(MSB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream bidirectional shift register model
   logic [MSB-1:0] sr;
   always @(posedge clk) begin
      if (rst)         sr <= '0;
      else if (bus.en) sr <= bus.dir ? {sr[MSB-2:0], bus.d} : {bus.d, sr[MSB-1:1]};
   end

   logic [1:0]     exp_bits  [$];   // {dir, d}
   logic [MSB-1:0] exp_words [$];
   int             rise_log  [$];
   int             done_log  [$];
   int             en_total = 0;
   logic           en_prev  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   // Monitor: compare every presented bit and every completed word
   always @(negedge clk) begin
      logic [1:0] eb;
      if (bus.en) begin
         en_total++;
         if (!en_prev) rise_log.push_back(cyc);
         if (exp_bits.size() == 0) begin
            chk("unexpected_en", 32'(bus.en), 32'd0);
         end else begin
            eb = exp_bits.pop_front();
            chk("bit_d", 32'(bus.d), 32'(eb[0]));
            chk("bit_dir", 32'(bus.dir), 32'(eb[1]));
         end
      end
      en_prev = bus.en;
      if (bus.word_done) begin
         done_log.push_back(cyc);
         if (exp_words.size() == 0) chk("unexpected_word_done", 32'(bus.word_done), 32'd0);
         else chk("word_out", 32'(sr), 32'(exp_words.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      rise_log.delete();
      done_log.delete();
      en_total = 0;
   endtask

   task automatic push_word(input logic [MSB-1:0] data, input logic wdir, output int pcyc);
      int n;
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      bus.in_dir   = wdir;
      n = 0;
      while (!bus.in_ready && n < 100) begin
         tick();
         n++;
      end
      if (n == 100) timeout_fail("push_ready");
      for (int i = 0; i < int'(MSB); i++)
         exp_bits.push_back({wdir, wdir ? data[MSB-1-i] : data[i]});
      exp_words.push_back(data);
      tick();
      pcyc = cyc;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_quiet(input string name);
      int n;
      n = 0;
      while ((bus.busy || bus.en) && n < 300) begin
         tick();
         n++;
      end
      if (n == 300) timeout_fail(name);
      tick();
      tick();
   endtask

   task automatic wait_en(input string name);
      int n;
      n = 0;
      while (!bus.en && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) timeout_fail(name);
   endtask

   initial begin
      int pc;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_dir   = 1'b0;
      bus.pause    = 1'b0;

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      chk("rst_en", 32'(bus.en), 32'd0);
      chk("rst_d", 32'(bus.d), 32'd0);
      chk("rst_dir", 32'(bus.dir), 32'd0);
      chk("rst_word_done", 32'(bus.word_done), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("circular", 32'(bus.circular), 32'd0);
      chk("carry_in", 32'(bus.carry_in), 32'd0);
      tick();

      // A5 right shift: 8 contiguous bits, first en two edges after push
      clear_logs();
      push_word(8'hA5, 1'b0, pc);
      wait_quiet("quiet_a5");
      chk("a5_en_count", 32'(en_total), 32'd8);
      chk("a5_en_runs", 32'(rise_log.size()), 32'd1);
      chk("a5_done_count", 32'(done_log.size()), 32'd1);
      if (rise_log.size() == 1 && done_log.size() == 1) begin
         chk("a5_latency", 32'(rise_log[0] - pc), 32'd2);
         chk("a5_first_en_to_done", 32'(done_log[0] - rise_log[0]), 32'd8);
      end
      chk("idle_d", 32'(bus.d), 32'd0);

      // 3C left shift: direction held afterwards
      clear_logs();
      push_word(8'h3C, 1'b1, pc);
      wait_quiet("quiet_3c");
      chk("3c_en_count", 32'(en_total), 32'd8);
      chk("3c_done_count", 32'(done_log.size()), 32'd1);
      chk("3c_dir_held", 32'(bus.dir), 32'd1);

      // Three back-to-back words
      clear_logs();
      push_word(8'h01, 1'b0, pc);
      push_word(8'h02, 1'b0, pc);
      push_word(8'h03, 1'b0, pc);
      chk("b2b_in_ready_full", 32'(bus.in_ready), 32'd0);
      wait_quiet("quiet_b2b");
      chk("b2b_en_count", 32'(en_total), 32'd24);
      chk("b2b_en_runs", 32'(rise_log.size()), 32'd1);
      chk("b2b_done_count", 32'(done_log.size()), 32'd3);
      if (done_log.size() == 3) begin
         chk("b2b_gap1", 32'(done_log[1] - done_log[0]), 32'd8);
         chk("b2b_gap2", 32'(done_log[2] - done_log[1]), 32'd8);
      end
      chk("b2b_in_ready_empty", 32'(bus.in_ready), 32'd1);

      // Pause for 3 cycles after bit 3
      clear_logs();
      push_word(8'hA5, 1'b0, pc);
      wait_en("pause_wait_en");
      for (int i = 0; i < 3; i++) tick();
      bus.pause = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      bus.pause = 1'b0;
      wait_quiet("quiet_pause");
      chk("pause_en_count", 32'(en_total), 32'd8);
      chk("pause_en_runs", 32'(rise_log.size()), 32'd2);
      chk("pause_done_count", 32'(done_log.size()), 32'd1);
      if (rise_log.size() == 2 && done_log.size() == 1) begin
         chk("pause_first_en_to_done", 32'(done_log[0] - rise_log[0]), 32'd11);
         chk("pause_resume_gap", 32'(rise_log[1] - rise_log[0]), 32'd7);
      end

      // Reset mid-word with a second word queued
      clear_logs();
      push_word(8'hA5, 1'b0, pc);
      push_word(8'h5A, 1'b0, pc);
      wait_en("rst_wait_en");
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      exp_bits.delete();
      exp_words.delete();
      rst = 1'b0;
      chk("midrst_en", 32'(bus.en), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 12; i++) tick();
      chk("midrst_no_done", 32'(done_log.size()), 32'd0);
      chk("midrst_en_count", 32'(en_total), 32'd5);
      clear_logs();
      push_word(8'h96, 1'b1, pc);
      wait_quiet("quiet_after_rst");
      chk("after_rst_en_count", 32'(en_total), 32'd8);
      chk("after_rst_done_count", 32'(done_log.size()), 32'd1);

      chk("leftover_bits", 32'(exp_bits.size()), 32'd0);
      chk("leftover_words", 32'(exp_words.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bidir_shift_feeder.md
BIDIR_SHIFT_FEEDER -- requirements
Module: bidir_shift_feeder

Interface
REQ-001 Parameter: MSB, default 8, word width in bits; equals the MSB parameter of the downstream bidirectional shift register.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream word available.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_data  input  MSB  parallel word to serialise.
REQ-007 in_dir  input  1  shift direction for this word: 0 = right shift, 1 = left shift.
REQ-008 pause  input  1  stall request; freezes serialisation while high.
REQ-009 d  output  1  serial bit to the shift register.
REQ-010 en  output  1  shift enable to the shift register.
REQ-011 dir  output  1  direction to the shift register.
REQ-012 circular  output  1  constant 0.
REQ-013 carry_in  output  1  constant 0.
REQ-014 word_done  output  1  one-cycle pulse; downstream parallel output holds the complete word.
REQ-015 busy  output  1  high while the FSM is in SHIFT or the FIFO is non-empty.

Function
REQ-016 The block SHALL contain a 2-entry FIFO holding {in_dir, in_data}; in_ready = FIFO not full (combinational from registered count).
REQ-017 A push SHALL occur at every edge with in_valid=1 and in_ready=1; a push and a pop in the same edge SHALL leave the count unchanged.
REQ-018 The FSM SHALL have states IDLE and SHIFT plus a bit counter of width clog2(MSB).
REQ-019 IDLE: at an edge with FIFO non-empty, the FSM SHALL pop the head word, set counter = 0, and enter SHIFT.
REQ-020 d, en and dir SHALL be registered outputs; en=1 only in SHIFT.
REQ-021 Bit order: dir=0 SHALL present the word LSB first (bit cnt); dir=1 SHALL present it MSB first (bit MSB-1-cnt).
REQ-022 dir SHALL be constant for all cycles of one word and SHALL hold its last value in IDLE.
REQ-023 Each cycle with en=1 SHALL present exactly one bit; the counter SHALL advance at each edge that ends an en=1 cycle.
REQ-024 pause=1 sampled at an edge in SHIFT SHALL force en=0 in the next cycle with d and counter unchanged; serialisation SHALL resume with the same bit in the cycle after pause is sampled low.
REQ-025 Latency: a word pushed into an empty FIFO while IDLE at edge e0 SHALL have its first en=1 cycle immediately after edge e0+2.
REQ-026 At the edge that ends the last bit (counter = MSB-1), the FSM SHALL pop the next word if the FIFO is non-empty and keep en=1 with no gap; otherwise it SHALL return to IDLE with en=0.
REQ-027 word_done SHALL be 1 for exactly one cycle: the cycle after the last en=1 cycle of each word, including under back-to-back operation.
REQ-028 In IDLE, d SHALL be 0.

Reset
REQ-029 rst=1 at an edge SHALL empty the FIFO and set FSM=IDLE, counter=0, d=0, en=0, dir=0, word_done=0 in the following cycle; busy=0 and in_ready=1 follow from that state.
REQ-030 Reset mid-word SHALL discard the partial word and any queued words; no word_done SHALL be generated for them.
REQ-031 Reset SHALL take priority over push, pop and pause.

Verification (MSB=8)
REQ-032 rst=1 for 2 cycles -> en=0, d=0, dir=0, word_done=0, busy=0, in_ready=1.
REQ-033 Push 8'hA5 with dir=0 -> en=1 for 8 consecutive cycles, d = 1,0,1,0,0,1,0,1, then word_done=1 for 1 cycle; downstream out = 8'hA5.
REQ-034 Push 8'h3C with dir=1 -> d = 0,0,1,1,1,1,0,0 with dir=1 on all 8 cycles; downstream out = 8'h3C at word_done.
REQ-035 Push 8'h01, 8'h02, 8'h03 on consecutive cycles, dir=0 -> in_ready=0 while 2 words are queued; en=1 continuously for 24 cycles; word_done pulses 3 times, 8 cycles apart, with out = 01, 02, 03.
REQ-036 pause=1 for 3 cycles after bit 3 of 8'hA5 -> en=0 for exactly 3 cycles, 11 cycles from first en to word_done, out = 8'hA5.
REQ-037 rst=1 after bit 4 with one word queued -> en=0 next cycle, busy=0, no word_done; a new push afterwards serialises correctly.
